// File: rtl/crc16_pkg.sv
// crc16_pkg
//   Shared constants and reference functions for the byte-parallel
//   CRC-16-CCITT generator (polynomial x^16+x^12+x^5+1, MSB first).
//   CRC16_POLY   : generator polynomial without the x^16 term
//   CRC16_INIT   : register preset value
//   CRC16_XOROUT : final XOR applied to the reflected output
//   crc16_next_byte(crc, data) : 8 serial LFSR steps, data bit 7 first
//   reverse16(value)           : full 16-bit bit reversal
package crc16_pkg;

  localparam logic [15:0] CRC16_POLY   = 16'h1021;
  localparam logic [15:0] CRC16_INIT   = 16'hFFFF;
  localparam logic [15:0] CRC16_XOROUT = 16'hFFFF;

  // Bit-serial form. It is kept as the readable definition of one byte
  // step; the datapath uses the flattened equations in
  // crc16_ccitt_byte_step, which compute the same function.
  function automatic logic [15:0] crc16_next_byte(input logic [15:0] crc,
                                                  input logic [7:0]  data);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int k = 7; k >= 0; k--) begin
      fb = c[15] ^ data[k];
      c  = {c[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    end
    return c;
  endfunction

  function automatic logic [15:0] reverse16(input logic [15:0] value);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) begin
      r[i] = value[15-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/crc16_ccitt_byte_step.sv
// crc16_ccitt_byte_step
//   Purely combinational: absorbs one byte into a CRC-16-CCITT value in a
//   single step (equivalent to 8 MSB-first serial LFSR shifts).
//   crc_i [15:0] : current CRC value
//   data_i [7:0] : byte to absorb, bit 7 first
//   crc_o [15:0] : CRC after absorbing data_i
module crc16_ccitt_byte_step
  import crc16_pkg::*;
(
  input  logic [15:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);

  // The byte feeding the polynomial is the top CRC byte XOR the data.
  // Because 0x1021 has no terms in bits 11..8 beyond x^12, folding the
  // upper nibble of that byte back onto itself (t = x ^ x>>4) yields the
  // exact feedback pattern; the remainder is three shifted copies of t
  // (x^12, x^5, x^0) on top of the CRC shifted left by one byte.
  logic [7:0] fb_byte;
  logic [7:0] fb_fold;

  always_comb begin
    fb_byte = crc_i[15:8] ^ data_i;
    fb_fold = fb_byte ^ {4'h0, fb_byte[7:4]};
    crc_o   = {crc_i[7:0], 8'h00}
            ^ {fb_fold[3:0], 12'h000}
            ^ {3'b000, fb_fold, 5'b00000}
            ^ {8'h00, fb_fold};
  end

endmodule

// File: rtl/crc_16_ccitt_parallel.sv
// crc_16_ccitt_parallel
//   Byte-parallel CRC-16-CCITT generator, one byte per clock when qualified.
//   i_Clk              : rising-edge clock
//   i_Rst              : asynchronous active-high reset, loads INIT_VALUE
//   i_Init             : synchronous re-initialise, wins over i_DV
//   i_DV               : absorb i_Data on this edge
//   i_Data [7:0]       : data byte, bit 7 shifted first
//   o_CRC [15:0]       : registered CRC value (CCITT-FALSE style)
//   o_CRC_Reversed_Xor : bit-reversed o_CRC XOR 0xFFFF (X-25 style when the
//                        caller supplies bit-reversed bytes)
module crc_16_ccitt_parallel
  import crc16_pkg::*;
#(
  parameter logic [15:0] INIT_VALUE = CRC16_INIT
)(
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Init,
  input  logic        i_DV,
  input  logic [7:0]  i_Data,
  output logic [15:0] o_CRC,
  output logic [15:0] o_CRC_Reversed_Xor
);

  logic [15:0] crc_q;
  logic [15:0] crc_d;
  logic [15:0] step_crc;

  crc16_ccitt_byte_step u_step (
    .crc_i  (crc_q),
    .data_i (i_Data),
    .crc_o  (step_crc)
  );

  // Init has priority; when neither strobe is set the register holds, so
  // whatever is on i_Data during idle cycles never reaches state.
  always_comb begin
    crc_d = crc_q;
    if (i_Init)
      crc_d = INIT_VALUE;
    else if (i_DV)
      crc_d = step_crc;
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst)
      crc_q <= INIT_VALUE;
    else
      crc_q <= crc_d;
  end

  assign o_CRC              = crc_q;
  assign o_CRC_Reversed_Xor = reverse16(crc_q) ^ CRC16_XOROUT;

endmodule

// File: tb/tb_crc_16_ccitt_parallel.sv
module tb_crc_16_ccitt_parallel;

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        i_Rst = 1'b0;
  logic        i_Init = 1'b0;
  logic        i_DV = 1'b0;
  logic [7:0]  i_Data = 8'h00;
  logic [15:0] o_CRC;
  logic [15:0] o_CRC_Reversed_Xor;

  crc_16_ccitt_parallel #(.INIT_VALUE(16'hFFFF)) dut (
    .i_Clk              (clk),
    .i_Rst              (i_Rst),
    .i_Init             (i_Init),
    .i_DV               (i_DV),
    .i_Data             (i_Data),
    .o_CRC              (o_CRC),
    .o_CRC_Reversed_Xor (o_CRC_Reversed_Xor)
  );

  initial forever begin
    #5;
    if (clk_en) clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [15:0] crc;
    logic [15:0] rev;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0;
  int   n_total = 0;
  logic [15:0] m;   // reference CRC state

  // Reference: the textbook bit-at-a-time polynomial division, in ints.
  function automatic logic [15:0] ref_next(input logic [15:0] c, input logic [7:0] d);
    int v;
    int fb;
    v = int'(c);
    for (int k = 7; k >= 0; k--) begin
      fb = ((v >> 15) & 1) ^ ((int'(d) >> k) & 1);
      v  = ((v << 1) & 32'hFFFF) ^ (fb != 0 ? 32'h1021 : 32'h0);
    end
    return v[15:0];
  endfunction

  function automatic logic [15:0] ref_rev(input logic [15:0] c);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = ~c[15-i];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
  endtask

  task automatic push(input int due, input logic [15:0] c, input logic [15:0] r, input string nm);
    exp_t e;
    e.due = due; e.crc = c; e.rev = r; e.name = nm;
    q.push_back(e);
  endtask

  // One driven cycle; the expected result becomes visible after the next edge.
  task automatic drive(input logic init, input logic dv, input logic [7:0] d, input string nm);
    @(posedge clk); #1;
    i_Init = init; i_DV = dv; i_Data = d;
    if (init)    m = 16'hFFFF;
    else if (dv) m = ref_next(m, d);
    push(cyc + 1, m, ref_rev(m), nm);
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_total++;
      $display("FAIL drain: %0d expected results never checked", q.size());
      q.delete();
    end
  endtask

  // Monitor: the register presents a new value every cycle; compare each
  // due expectation on the falling edge.
  always @(negedge clk) begin : mon
    exp_t e;
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      chk({e.name, ".crc"}, o_CRC, e.crc);
      chk({e.name, ".rev"}, o_CRC_Reversed_Xor, e.rev);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

  logic [7:0] msg [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

  initial begin
    // Async reset with no clock running
    #2 i_Rst = 1'b1;
    #1;
    chk("rst_noclk.crc", o_CRC, 16'hFFFF);
    chk("rst_noclk.rev", o_CRC_Reversed_Xor, 16'h0000);
    m = 16'hFFFF;
    clk_en = 1'b1;
    repeat (2) @(negedge clk);
    i_Rst = 1'b0;

    // Standard check value, with an idle gap before the last byte
    drive(1, 0, 8'h00, "std_init");
    for (int i = 0; i < 8; i++) drive(0, 1, msg[i], "std_byte");
    for (int i = 0; i < 10; i++) drive(0, 0, 8'($urandom), "std_gap");
    drive(0, 1, 8'h39, "std_last");
    push(cyc + 1, 16'h29B1, 16'h726B, "std_const");
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 8'($urandom), "std_hold");
      push(cyc + 1, 16'h29B1, 16'h726B, "std_hold_const");
    end

    // Reflected (X-25) mode: bit-reversed "ES"
    drive(1, 0, 8'h00, "x25_init");
    drive(0, 1, 8'hA2, "x25_b0");
    drive(0, 1, 8'hCA, "x25_b1");
    push(cyc + 1, 16'h1E15, 16'h5787, "x25_const");
    drive(0, 0, 8'h00, "x25_idle");

    // Init together with DV mid-stream: byte is dropped
    drive(0, 1, 8'h5A, "pri_b0");
    drive(0, 1, 8'hC3, "pri_b1");
    drive(1, 1, 8'h77, "pri_both");
    push(cyc + 1, 16'hFFFF, 16'h0000, "pri_const");
    drive(0, 1, 8'h31, "pri_after");

    // Hold: 50 idle cycles with random data on the bus
    drive(0, 1, 8'h9E, "hold_seed");
    for (int i = 0; i < 50; i++) drive(0, 0, 8'($urandom), "hold");

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      int r;
      r = $urandom_range(0, 99);
      drive(r < 4, r < 65, 8'($urandom), "rand");
    end
    drain();

    // Async reset between edges, mid-stream
    for (int i = 0; i < 4; i++) drive(0, 1, 8'($urandom), "mid_byte");
    drive(0, 0, 8'h00, "mid_idle");
    drain();
    @(posedge clk); #2;
    i_Rst = 1'b1;
    #1;
    chk("rst_mid.crc", o_CRC, 16'hFFFF);
    chk("rst_mid.rev", o_CRC_Reversed_Xor, 16'h0000);
    m = 16'hFFFF;
    @(negedge clk);
    i_Rst = 1'b0;
    for (int i = 0; i < 9; i++) drive(0, 1, msg[i], "post_rst");
    push(cyc + 1, 16'h29B1, 16'h726B, "post_rst_const");
    drive(0, 0, 8'h00, "post_rst_idle");
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/crc_16_ccitt_parallel.md
Name: crc_16_ccitt_parallel

Overview:
- Byte-parallel CRC-16-CCITT generator: polynomial x^16+x^12+x^5+1 (0x1021), initial value 0xFFFF.
- Absorbs one 8-bit data byte per clock when the byte is qualified by a valid strobe. Bytes need not arrive on consecutive cycles.
- Sits beside a byte-stream interface (framer or UART-style link) to produce frame check sequences.
- Provides two outputs:
  - the raw CRC (CRC-16/CCITT-FALSE convention when fed MSB-first bytes);
  - a reflected, inverted CRC (CRC-16/X-25 convention when the caller feeds bit-reversed bytes).

Parameters:
- INIT_VALUE, 16'hFFFF, value loaded into the CRC register on reset and on i_Init.

Ports:
- i_Clk  input  1  system clock; all state changes on the rising edge.
- i_Rst  input  1  asynchronous, active-high reset.
- i_Init  input  1  synchronous re-initialise; loads INIT_VALUE.
- i_DV  input  1  data valid; i_Data is absorbed on an edge where i_DV=1.
- i_Data  input  8  data byte; bit 7 is shifted first.
- o_CRC  output  16  current CRC register value.
- o_CRC_Reversed_Xor  output  16  full 16-bit bit-reversal of o_CRC, XORed with 16'hFFFF.

Behaviour:
- Reset:
  - While i_Rst=1, asynchronously, the CRC register = INIT_VALUE.
  - So o_CRC=16'hFFFF and o_CRC_Reversed_Xor=16'h0000.
  - Reset asserted mid-stream discards all accumulated state immediately.
- Priority on each rising edge (i_Rst=0):
  - If i_Init=1: crc <= INIT_VALUE. i_DV is ignored that cycle; Init wins on simultaneous assertion.
  - Else if i_DV=1: crc <= next(crc, i_Data).
  - Else: crc holds.
- next(c, d): equivalent to 8 serial LFSR steps, MSB first. For k = 7 down to 0:
  - fb = c[15] ^ d[k];
  - c = {c[14:0],1'b0} ^ (fb ? 16'h1021 : 16'h0000).
- next() is implemented as flattened combinational XOR equations, so one byte is absorbed per clock with no throughput limit.
- Latency:
  - o_CRC reflects a byte on the cycle after the edge that absorbed it; it is a registered output.
  - o_CRC_Reversed_Xor is combinational from the register: out[i] = ~crc[15-i] for i = 0..15. It has the same latency as o_CRC.
- Back-to-back i_DV cycles are fully supported. Idle gaps of any length between bytes do not alter the result.
- No bit-reversal is applied to i_Data internally. For reflected-input protocols (X-25/HDLC), the caller supplies bit-reversed bytes and uses o_CRC_Reversed_Xor.
- X or Z on i_Data while i_DV=0 must not affect state.

Decomposition:
- Package crc16_pkg holds:
  - localparam CRC16_POLY = 16'h1021;
  - localparam CRC16_INIT = 16'hFFFF;
  - localparam CRC16_XOROUT = 16'hFFFF;
  - pure functions crc16_next_byte(crc, data) and reverse16(value).
- One combinational sub-module, crc16_ccitt_byte_step, maps (crc_in[15:0], data[7:0]) to crc_out[15:0]. The top module wraps it with the register, Init/DV priority and output mapping.

Test Plan:
- Reset: assert i_Rst with no clock running -> o_CRC=16'hFFFF and o_CRC_Reversed_Xor=16'h0000 immediately.
- Standard check:
  - Stimulus: pulse i_Init, then feed ASCII "123456789" (0x31..0x39); 8 bytes consecutive, then 10 idle cycles, then 0x39.
  - Required: o_CRC=16'h29B1 and o_CRC_Reversed_Xor=16'h726B one cycle after the last byte; both hold while i_DV=0.
- Reflected mode:
  - Stimulus: pulse i_Init, then feed bit-reversed 0x45 and 0x53 (0xA2, 0xCA) back-to-back.
  - Required: o_CRC_Reversed_Xor=16'h5787.
- Init priority: mid-stream, assert i_Init and i_DV together -> o_CRC=16'hFFFF next cycle; the data byte is not absorbed.
- Hold: 50 cycles with i_DV=0 and random i_Data -> o_CRC unchanged.
- Async reset mid-stream: assert i_Rst between clock edges after several bytes -> o_CRC=16'hFFFF without waiting for an edge. After release, re-running "123456789" gives 16'h29B1.
